// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: RV32I funct3 codes,
// memory write-enable encodings and the FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MEM_WR_NONE = 4'd0;
  localparam logic [3:0] MEM_WR_WORD = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_RMW_WAIT  = 3'd2,
    S_SETTLE    = 3'd3,
    S_RESP      = 3'd4
  } lsu_state_e;

  // funct3[1] marks a word access and funct3[0] a halfword access.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    if (funct3[1]) return off != 2'b00;
    if (funct3[0]) return off[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of request, data-memory and response signals around the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1;
// the requester holds all req_* fields stable while req_valid=1 and req_ready=0.
interface lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic [31:0] mem_addr;
  logic [3:0]  mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_is_load;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  lsu_state_e  state_dbg;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, mem_addr, mem_write, mem_wdata,
    output resp_valid, resp_is_load, resp_data, resp_rd, resp_err, state_dbg
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, mem_addr, mem_write, mem_wdata,
    input  resp_valid, resp_is_load, resp_data, resp_rd, resp_err, state_dbg
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a loaded byte or half and merges a
// store byte or half into an old word for read-modify-write.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] o,
                                               input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {o, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'h0, sh[7:0]};
      F3_HU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] o, input logic [2:0] f3);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh   = {o, 3'b000};
    mask = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  assign load_data = load_extract(rdata, off, funct3);
  assign merged    = store_merge(rdata, wdata, off, funct3);

endmodule

// File: rtl/load_store_unit.sv
// Requester side of the data-memory port: sequences loads, word stores and
// byte/half read-modify-write stores against a memory with 1-cycle read and write-commit delay.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input logic clk,
  input logic reset,
  lsu_if.slave bus
);

  lsu_state_e  state;
  logic        cap_store;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [4:0]  cap_rd;

  logic        resp_valid_q;
  logic        resp_is_load_q;
  logic        resp_err_q;
  logic [31:0] resp_data_q;
  logic [4:0]  resp_rd_q;

  logic        accept;
  logic        req_err;
  logic        req_sw;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept  = bus.req_valid && (state == S_IDLE);
  assign req_err = misaligned(bus.req_funct3, bus.req_addr[1:0]) ||
                   (bus.req_addr[31:ADDR_BITS] != '0);
  assign req_sw  = bus.req_store && bus.req_funct3[1];

  lsu_byte_lane u_lane (
    .rdata     (bus.mem_rdata),
    .wdata     (cap_wdata),
    .off       (cap_addr[1:0]),
    .funct3    (cap_funct3),
    .load_data (load_data),
    .merged    (merged)
  );

  // IDLE forwards the request address so the memory read starts in the accept cycle.
  always_comb begin
    bus.mem_addr  = cap_addr;
    bus.mem_write = MEM_WR_NONE;
    bus.mem_wdata = '0;
    case (state)
      S_IDLE: begin
        bus.mem_addr = bus.req_addr;
        if (accept && req_sw && !req_err) begin
          bus.mem_write = MEM_WR_WORD;
          bus.mem_wdata = bus.req_wdata;
        end
      end
      S_RMW_WAIT: begin
        bus.mem_write = MEM_WR_WORD;
        bus.mem_wdata = merged;
      end
      default: ;
    endcase
  end

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_is_load = resp_is_load_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_rd      = resp_rd_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.state_dbg    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cap_store      <= 1'b0;
      cap_funct3     <= '0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      cap_rd         <= '0;
      resp_valid_q   <= 1'b0;
      resp_is_load_q <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_data_q    <= '0;
      resp_rd_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_store  <= bus.req_store;
            cap_funct3 <= bus.req_funct3;
            cap_addr   <= bus.req_addr;
            cap_wdata  <= bus.req_wdata;
            cap_rd     <= bus.req_rd;
            if (req_err) begin
              resp_valid_q   <= 1'b1;
              resp_is_load_q <= !bus.req_store;
              resp_err_q     <= 1'b1;
              resp_data_q    <= '0;
              resp_rd_q      <= bus.req_rd;
              state          <= S_RESP;
            end else if (!bus.req_store) begin
              state <= S_LOAD_WAIT;
            end else if (req_sw) begin
              state <= S_SETTLE;
            end else begin
              state <= S_RMW_WAIT;
            end
          end
        end
        S_LOAD_WAIT: begin
          resp_valid_q   <= 1'b1;
          resp_is_load_q <= 1'b1;
          resp_err_q     <= 1'b0;
          resp_data_q    <= load_data;
          resp_rd_q      <= cap_rd;
          state          <= S_RESP;
        end
        S_RMW_WAIT: state <= S_SETTLE;
        // Memory commits the write on this edge; responding afterwards keeps a following load coherent.
        S_SETTLE: begin
          resp_valid_q   <= 1'b1;
          resp_is_load_q <= !cap_store;
          resp_err_q     <= 1'b0;
          resp_data_q    <= '0;
          resp_rd_q      <= cap_rd;
          state          <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table against a delayed-commit memory
// model, plus reset-mid-RMW and back-to-back load sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_if bus();

  load_store_unit #(.ADDR_BITS(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory: registered read, write sampled on one edge and committed on the next.
  logic [31:0] mem [128];
  logic        mem_init;
  logic        wr_pend;
  logic [6:0]  wr_idx;
  logic [31:0] wr_data;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'(i + 12);
    end else if (wr_pend && !reset) begin
      mem[wr_idx] <= wr_data;
    end
    if (reset) wr_pend <= 1'b0;
    else       wr_pend <= (bus.mem_write == MEM_WR_WORD);
    wr_idx        <= bus.mem_addr[8:2];
    wr_data       <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[8:2]];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] data;
    logic        err;
    int          wr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input int lat, input logic [31:0] data, input logic err, input int wr);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
    v.lat = lat; v.data = data; v.err = err; v.wr = wr;
    vecs.push_back(v);
  endtask

  // Drives one request starting at posedge+1 and follows it until its response.
  task automatic run_req(input vec_t v, output int lat, output int wr_cycles, output int bad_cycles,
                         output logic [31:0] r_data, output logic r_err, output logic r_isl,
                         output logic [4:0] r_rd);
    int cyc;
    bit acc;
    lat = -1; wr_cycles = 0; bad_cycles = 0; acc = 0; cyc = 0;
    r_data = '0; r_err = 1'b0; r_isl = 1'b0; r_rd = '0;
    bus.req_valid  = 1'b1;
    bus.req_store  = v.st;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wd;
    bus.req_rd     = v.rd;
    for (int t = 0; t < 20 && lat < 0; t++) begin
      #1;
      if (!acc && bus.req_ready) acc = 1;
      if (acc) begin
        if (bus.mem_write != MEM_WR_NONE) wr_cycles++;
        if (bus.mem_write > MEM_WR_WORD) bad_cycles++;
        if (cyc > 0 && bus.req_ready) bad_cycles++;
        if (bus.resp_valid) begin
          lat = cyc;
          r_data = bus.resp_data; r_err = bus.resp_err;
          r_isl = bus.resp_is_load; r_rd = bus.resp_rd;
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        bus.req_valid = 1'b0;
        cyc++;
      end
    end
  endtask

  task automatic apply(input vec_t v);
    int lat, wrc, bad;
    logic [31:0] d;
    logic e, il;
    logic [4:0] rd;
    run_req(v, lat, wrc, bad, d, e, il, rd);
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " data"}, d, v.data);
    check({v.name, " err"}, {31'h0, e}, {31'h0, v.err});
    check({v.name, " is_load"}, {31'h0, il}, {31'h0, !v.st});
    check({v.name, " rd"}, {27'h0, rd}, {27'h0, v.rd});
    check({v.name, " write cycles"}, 32'(wrc), 32'(v.wr));
    check({v.name, " busy/ready or bad write"}, 32'(bad), 32'd0);
    #1;
    check({v.name, " valid drops"}, {31'h0, bus.resp_valid}, 32'h0);
    check({v.name, " data held"}, bus.resp_data, v.data);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_q[$];

  initial begin
    int n_resp, last_acc, idx, resp_seen;
    bit adv;
    vec_t v;

    reset = 1'b1; mem_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset mem_write", {28'h0, bus.mem_write}, 32'h0);
    check("reset mem_wdata", bus.mem_wdata, 32'h0);
    check("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("reset resp_is_load", {31'h0, bus.resp_is_load}, 32'h0);
    check("reset resp_data", bus.resp_data, 32'h0);
    check("reset resp_rd", {27'h0, bus.resp_rd}, 32'h0);
    check("reset resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("reset state", {29'h0, bus.state_dbg}, {29'h0, S_IDLE});
    reset = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;

    add_vec("lw_0c",   0, F3_W,  32'h0C,  32'h0,        5'd1,  2, 32'h0000000F, 0, 0);
    add_vec("sw_10",   1, F3_W,  32'h10,  32'hDEADBEEF, 5'd2,  2, 32'h0,        0, 1);
    add_vec("lw_10",   0, F3_W,  32'h10,  32'h0,        5'd3,  2, 32'hDEADBEEF, 0, 0);
    add_vec("sb_12",   1, F3_B,  32'h12,  32'h00000080, 5'd4,  3, 32'h0,        0, 1);
    add_vec("lw_10b",  0, F3_W,  32'h10,  32'h0,        5'd5,  2, 32'hDE80BEEF, 0, 0);
    add_vec("lb_12",   0, F3_B,  32'h12,  32'h0,        5'd6,  2, 32'hFFFFFF80, 0, 0);
    add_vec("lbu_12",  0, F3_BU, 32'h12,  32'h0,        5'd7,  2, 32'h00000080, 0, 0);
    add_vec("lh_12",   0, F3_H,  32'h12,  32'h0,        5'd8,  2, 32'hFFFFDE80, 0, 0);
    add_vec("lh_13",   0, F3_H,  32'h13,  32'h0,        5'd9,  1, 32'h0,        1, 0);
    add_vec("sw_201",  1, F3_W,  32'h201, 32'h12345678, 5'd10, 1, 32'h0,        1, 0);
    add_vec("lw_200",  0, F3_W,  32'h200, 32'h0,        5'd11, 1, 32'h0,        1, 0);
    add_vec("lw_1fc",  0, F3_W,  32'h1FC, 32'h0,        5'd12, 2, 32'h0000008B, 0, 0);
    add_vec("sh_1a",   1, F3_H,  32'h1A,  32'h1234ABCD, 5'd13, 3, 32'h0,        0, 1);
    add_vec("lw_18",   0, F3_W,  32'h18,  32'h0,        5'd14, 2, 32'hABCD0012, 0, 0);
    add_vec("lhu_1a",  0, F3_HU, 32'h1A,  32'h0,        5'd15, 2, 32'h0000ABCD, 0, 0);
    add_vec("lh_18",   0, F3_H,  32'h18,  32'h0,        5'd16, 2, 32'h00000012, 0, 0);
    add_vec("lb_1b",   0, F3_B,  32'h1B,  32'h0,        5'd17, 2, 32'hFFFFFFAB, 0, 0);
    add_vec("sb_19",   1, F3_B,  32'h19,  32'h000000FF, 5'd18, 3, 32'h0,        0, 1);
    add_vec("lbu_19",  0, F3_BU, 32'h19,  32'h0,        5'd19, 2, 32'h000000FF, 0, 0);
    add_vec("lw_18b",  0, F3_W,  32'h18,  32'h0,        5'd20, 2, 32'hABCDFF12, 0, 0);
    add_vec("sh_15",   1, F3_H,  32'h15,  32'h0000BEEF, 5'd21, 1, 32'h0,        1, 0);
    add_vec("lw_12",   0, F3_W,  32'h12,  32'h0,        5'd22, 1, 32'h0,        1, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset while the SB read-modify-write is about to write back.
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h14; bus.req_wdata = 32'h55; bus.req_rd = 5'd23;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1;
    check("rmw state before reset", {29'h0, bus.state_dbg}, {29'h0, S_RMW_WAIT});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post-reset mem_write", {28'h0, bus.mem_write}, 32'h0);
    check("post-reset state", {29'h0, bus.state_dbg}, {29'h0, S_IDLE});
    resp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.resp_valid || bus.mem_write != MEM_WR_NONE) resp_seen++;
      @(posedge clk); #1;
    end
    check("no resp/write after reset", 32'(resp_seen), 32'h0);
    v.name = "lw_14_after_reset"; v.st = 0; v.f3 = F3_W; v.addr = 32'h14; v.wd = 0; v.rd = 5'd24;
    v.lat = 2; v.data = 32'h00000011; v.err = 0; v.wr = 0;
    apply(v);

    // Back-to-back loads with req_valid held high.
    exp_q = {32'h0000000C, 32'h0000000D, 32'h0000000E};
    idx = 0; n_resp = 0; last_acc = -1; adv = 0;
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h0; bus.req_rd = 5'd25;
    for (int c = 0; c < 40 && n_resp < 3; c++) begin
      #1;
      if (bus.req_valid && bus.req_ready) begin
        if (last_acc >= 0) check("b2b accept spacing", 32'(c - last_acc), 32'd3);
        last_acc = c;
        adv = 1;
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b unexpected response", bus.resp_data, 32'hFFFF_FFFF);
        end else begin
          check("b2b load data", bus.resp_data, exp_q.pop_front());
        end
        n_resp++;
      end
      @(posedge clk); #1;
      if (adv) begin
        adv = 0;
        idx++;
        if (idx < 3) bus.req_addr = 32'(idx * 4);
        else bus.req_valid = 1'b0;
      end
    end
    check("b2b response count", 32'(n_resp), 32'd3);
    check("b2b queue drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
